// File: rtl/fx_bm_pkg.sv
// FX bus monitor shared constants: defaults, record layout, width helper.
// Optional timestamp field enabled by FX_BM_TS_EN.
package fx_bm_pkg;

  localparam int AW_DEF    = 16;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 16;
  localparam int TS_W_DEF  = 16;

  // Record layout for the default widths, LSB first.
  localparam int RDATA_LSB = 0;
  localparam int WDATA_LSB = DW_DEF;
  localparam int ADDR_LSB  = 2 * DW_DEF;
  localparam int DIR_BIT   = 2 * DW_DEF + AW_DEF;
  localparam int TS_LSB    = DIR_BIT + 1;

  localparam logic [15:0] OVF_MAX = 16'hFFFF;

  function automatic int fx_bm_rw(int aw, int dw, int tsw);
`ifdef FX_BM_TS_EN
    return 1 + aw + 2 * dw + tsw;
`else
    if (tsw < 0) return 0;
    return 1 + aw + 2 * dw;
`endif
  endfunction

endpackage

// File: rtl/fx_bm_sfifo.sv
// Generic first-word-fall-through FIFO with registered level and flush.
// Flush wins over same-cycle push/pop; pop on empty is ignored.
module fx_bm_sfifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rdata_o,
  output logic                   vld_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   level_q, level_d;
  logic          empty, full, push_ok, pop_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (PW+1)'(DEPTH));
  assign pop_ok  = pop_i & ~empty;
  assign push_ok = push_i & (~full | pop_ok);

  assign rdata_o = mem_q[rptr_q];
  assign vld_o   = ~empty;
  assign full_o  = full;
  assign level_o = level_q;

  // Next pointer/level values; flush returns everything to empty.
  always_comb begin
    wptr_d  = wptr_q + PW'(push_ok);
    rptr_d  = rptr_q + PW'(pop_ok);
    level_d = level_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end
  end

  // Pointer and level state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage; cleared on reset so the head reads zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok && !flush_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fx_bm_fifo.sv
// FX bus monitor: captures strobes, filters by window, buffers records.
// FX_BM_TS_EN prepends a free-running timestamp to each record.
module fx_bm_fifo
  import fx_bm_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TS_W  = TS_W_DEF
) (
  input  logic                               clk_sys,
  input  logic                               rst_n,
  input  logic [AW-1:0]                      fx_waddr,
  input  logic                               fx_wr,
  input  logic [DW-1:0]                      fx_data,
  input  logic                               fx_rd,
  input  logic [AW-1:0]                      fx_raddr,
  input  logic [DW-1:0]                      fx_q,
  input  logic                               cfg_win_en,
  input  logic [AW-1:0]                      cfg_lo,
  input  logic [AW-1:0]                      cfg_hi,
  input  logic                               bm_clr,
  output logic [fx_bm_rw(AW, DW, TS_W)-1:0]  bm_data,
  output logic                               bm_vld,
  input  logic                               bm_rdy,
  output logic [$clog2(DEPTH):0]             bm_level,
  output logic [15:0]                        bm_ovf_cnt
);

  localparam int RW = fx_bm_rw(AW, DW, TS_W);

  logic [AW-1:0] s0_addr;
  logic          s0_cap;
  logic          s1_vld_q;
  logic          s1_dir_q;
  logic [AW-1:0] s1_addr_q;
  logic [DW-1:0] s1_wdata_q;
  logic [RW-1:0] rec;
  logic          full, pop, drop;
  logic [15:0]   ovf_q, ovf_d;

  // Writes win when both strobes fire; window is inclusive, unsigned.
  assign s0_addr = fx_wr ? fx_waddr : fx_raddr;
  assign s0_cap  = (fx_wr | fx_rd) &
                   (~cfg_win_en | ((s0_addr >= cfg_lo) &&
                                   (s0_addr <= cfg_hi)));

  // Stage 0 -> stage 1 capture register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_dir_q   <= 1'b0;
      s1_addr_q  <= '0;
      s1_wdata_q <= '0;
    end else begin
      s1_vld_q <= s0_cap;
      if (s0_cap) begin
        s1_dir_q   <= fx_wr;
        s1_addr_q  <= s0_addr;
        s1_wdata_q <= fx_wr ? fx_data : '0;
      end
    end
  end

`ifdef FX_BM_TS_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] s1_ts_q;

  // Free-running timestamp, sampled alongside stage 0.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ts_q    <= '0;
      s1_ts_q <= '0;
    end else begin
      ts_q <= bm_clr ? '0 : ts_q + 1'b1;
      if (s0_cap) s1_ts_q <= ts_q;
    end
  end

  assign rec = {s1_ts_q, s1_dir_q, s1_addr_q, s1_wdata_q, fx_q};
`else
  assign rec = {s1_dir_q, s1_addr_q, s1_wdata_q, fx_q};
`endif

  assign pop  = bm_vld & bm_rdy;
  assign drop = s1_vld_q & full & ~pop;

  // Saturating drop counter; clear has priority.
  always_comb begin
    ovf_d = ovf_q;
    if (bm_clr) ovf_d = '0;
    else if (drop && ovf_q != OVF_MAX) ovf_d = ovf_q + 16'd1;
  end

  // Drop counter state.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) ovf_q <= '0;
    else        ovf_q <= ovf_d;
  end

  assign bm_ovf_cnt = ovf_q;

  fx_bm_sfifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_sys),
    .rst_ni  (rst_n),
    .flush_i (bm_clr),
    .push_i  (s1_vld_q),
    .wdata_i (rec),
    .pop_i   (bm_rdy),
    .rdata_o (bm_data),
    .vld_o   (bm_vld),
    .full_o  (full),
    .level_o (bm_level)
  );

endmodule

// File: tb/tb_fx_bm_fifo.sv
// Bench for fx_bm_fifo: directed vectors, corner sequences, random vs model.
// Timestamp checks are included when FX_BM_TS_EN is defined.
module tb_fx_bm_fifo;
  import fx_bm_pkg::*;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int TS_W  = 16;
  localparam int BASE  = 1 + AW + 2 * DW;
`ifdef FX_BM_TS_EN
  localparam int RW = BASE + TS_W;
`else
  localparam int RW = BASE;
`endif

  logic          clk_sys, rst_n;
  logic [AW-1:0] fx_waddr, fx_raddr, cfg_lo, cfg_hi;
  logic          fx_wr, fx_rd, cfg_win_en, bm_clr, bm_rdy, bm_vld;
  logic [DW-1:0] fx_data, fx_q;
  logic [RW-1:0] bm_data;
  logic [4:0]    bm_level;
  logic [15:0]   bm_ovf_cnt;

  fx_bm_fifo #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .TS_W(TS_W)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data),
    .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q),
    .cfg_win_en(cfg_win_en), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .bm_clr(bm_clr), .bm_data(bm_data), .bm_vld(bm_vld),
    .bm_rdy(bm_rdy), .bm_level(bm_level), .bm_ovf_cnt(bm_ovf_cnt)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  logic [63:0] q_m[$];
  logic        pend_vld;
  logic [63:0] pend_hi;
  logic [15:0] ovf_m, ts_m;

  typedef struct {
    logic          wr, rd;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] d, q;
    logic          wen;
    logic [AW-1:0] lo, hi;
    logic          ev;
    logic [BASE-1:0] er;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    pend_vld = 1'b0;
    pend_hi  = '0;
    ovf_m    = '0;
    ts_m     = '0;
  endtask

  // Predicts the effect of the coming clock edge from current inputs.
  task automatic model_edge();
    logic [63:0]   rec;
    logic [AW-1:0] a;
    bit            pop;
    rec = pend_hi | 64'(fx_q);
    pop = (q_m.size() > 0) && bm_rdy;
    if (bm_clr) begin
      q_m.delete();
      ovf_m = '0;
    end else begin
      if (pop) void'(q_m.pop_front());
      if (pend_vld) begin
        if (q_m.size() < DEPTH) q_m.push_back(rec);
        else if (ovf_m != 16'hFFFF) ovf_m = ovf_m + 16'd1;
      end
    end
    a = fx_wr ? fx_waddr : fx_raddr;
    pend_vld = (fx_wr | fx_rd) &&
               (!cfg_win_en || (a >= cfg_lo && a <= cfg_hi));
    pend_hi = (64'(fx_wr) << (BASE - 1)) | (64'(a) << (2 * DW));
    if (fx_wr) pend_hi = pend_hi | (64'(fx_data) << DW);
`ifdef FX_BM_TS_EN
    pend_hi = pend_hi | (64'(ts_m) << BASE);
`endif
    ts_m = bm_clr ? 16'd0 : ts_m + 16'd1;
  endtask

  task automatic chk_model();
    chk("vld", 64'(bm_vld), 64'(q_m.size() > 0));
    chk("level", 64'(bm_level), 64'(q_m.size()));
    chk("ovf", 64'(bm_ovf_cnt), 64'(ovf_m));
    if (q_m.size() > 0) chk("data", 64'(bm_data), q_m[0]);
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk_model();
  endtask

  task automatic idle_in();
    fx_wr = 1'b0;
    fx_rd = 1'b0;
  endtask

  task automatic clr();
    bm_clr = 1'b1;
    cyc();
    bm_clr = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    fx_wr    = 1'b1;
    fx_waddr = a;
    fx_data  = d;
    fx_q     = d ^ 8'hFF;
    cyc();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 8'hA5, 8'h3C,
                1'b0, 16'h0, 16'h0, 1'b1,
                {1'b1, 16'h0012, 8'hA5, 8'h3C}};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 16'h0040, 8'h5A, 8'h77,
                1'b0, 16'h0, 16'h0, 1'b1,
                {1'b0, 16'h0040, 8'h00, 8'h77}};
    vecs[2] = '{1'b1, 1'b1, 16'h1234, 16'h4321, 8'h11, 8'h22,
                1'b0, 16'h0, 16'h0, 1'b1,
                {1'b1, 16'h1234, 8'h11, 8'h22}};
    vecs[3] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 8'h01, 8'h02,
                1'b1, 16'h0100, 16'h01FF, 1'b0, '0};
    vecs[4] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 8'h03, 8'h04,
                1'b1, 16'h0100, 16'h01FF, 1'b1,
                {1'b1, 16'h0100, 8'h03, 8'h04}};
    vecs[5] = '{1'b1, 1'b0, 16'h01FF, 16'h0000, 8'h05, 8'h06,
                1'b1, 16'h0100, 16'h01FF, 1'b1,
                {1'b1, 16'h01FF, 8'h05, 8'h06}};
    vecs[6] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 8'h07, 8'h08,
                1'b1, 16'h0100, 16'h01FF, 1'b0, '0};
    vecs[7] = '{1'b0, 1'b1, 16'h0000, 16'h0150, 8'h09, 8'h0A,
                1'b1, 16'h0100, 16'h01FF, 1'b1,
                {1'b0, 16'h0150, 8'h00, 8'h0A}};
    vecs[8] = '{1'b1, 1'b0, 16'h0250, 16'h0000, 8'h0B, 8'h0C,
                1'b1, 16'h0300, 16'h0200, 1'b0, '0};
    vecs[9] = '{1'b0, 1'b1, 16'h0150, 16'h0050, 8'h0D, 8'h0E,
                1'b1, 16'h0100, 16'h01FF, 1'b0, '0};

    rst_n = 1'b0;
    fx_wr = 1'b0; fx_rd = 1'b0;
    fx_waddr = '0; fx_raddr = '0;
    fx_data = '0; fx_q = '0;
    cfg_win_en = 1'b0; cfg_lo = '0; cfg_hi = '0;
    bm_clr = 1'b0; bm_rdy = 1'b0;
    model_reset();
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("rst_vld", 64'(bm_vld), 64'd0);
    chk("rst_level", 64'(bm_level), 64'd0);
    chk("rst_ovf", 64'(bm_ovf_cnt), 64'd0);
    chk("rst_data", 64'(bm_data), 64'd0);
    rst_n = 1'b1;

    // Directed single transactions.
    for (int i = 0; i < NV; i++) begin
      cfg_win_en = vecs[i].wen;
      cfg_lo     = vecs[i].lo;
      cfg_hi     = vecs[i].hi;
      clr();
      fx_wr    = vecs[i].wr;
      fx_rd    = vecs[i].rd;
      fx_waddr = vecs[i].wa;
      fx_raddr = vecs[i].ra;
      fx_data  = vecs[i].d;
      cyc();
      idle_in();
      fx_q = vecs[i].q;
      chk($sformatf("vec%0d_lat", i), 64'(bm_vld), 64'd0);
      cyc();
      chk($sformatf("vec%0d_vld", i), 64'(bm_vld), 64'(vecs[i].ev));
      if (vecs[i].ev)
        chk($sformatf("vec%0d_rec", i),
            64'(bm_data[BASE-1:0]), 64'(vecs[i].er));
      bm_rdy = 1'b1;
      cyc();
      bm_rdy = 1'b0;
    end

    // Overfill with 20 back-to-back writes, then drain in order.
    cfg_win_en = 1'b0;
    clr();
    for (int i = 0; i < 20; i++) wr(16'(i), 8'(i + 8'h40));
    idle_in();
    cyc();
    chk("fill_level", 64'(bm_level), 64'd16);
    chk("fill_ovf", 64'(bm_ovf_cnt), 64'd4);
    bm_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_addr", i),
          64'(bm_data[2*DW +: AW]), 64'(i));
      cyc();
    end
    chk("drain_empty", 64'(bm_vld), 64'd0);
    bm_rdy = 1'b0;

    // Refill, then push and pop together while full.
    for (int i = 0; i < 16; i++) wr(16'(16'h0100 + i), 8'(i));
    idle_in();
    cyc();
    chk("refill_level", 64'(bm_level), 64'd16);
    wr(16'h00AA, 8'hAA);
    idle_in();
    bm_rdy = 1'b1;
    cyc();
    bm_rdy = 1'b0;
    chk("pp_level", 64'(bm_level), 64'd16);
    chk("pp_ovf", 64'(bm_ovf_cnt), 64'd4);

    // Saturation: preload near the top, then keep dropping.
    ovf_m = 16'hFFFE;
    force dut.ovf_q = 16'hFFFE;
    cyc();
    release dut.ovf_q;
    for (int i = 0; i < 3; i++) wr(16'h0ABC, 8'h55);
    idle_in();
    cyc();
    chk("sat_ovf", 64'(bm_ovf_cnt), 64'hFFFF);

    // Reset mid-stream with five records held.
    bm_rdy = 1'b1;
    for (int i = 0; i < 11; i++) cyc();
    bm_rdy = 1'b0;
    chk("pre_rst_level", 64'(bm_level), 64'd5);
    fx_wr = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 64'(bm_vld), 64'd0);
    chk("mid_rst_level", 64'(bm_level), 64'd0);
    chk("mid_rst_ovf", 64'(bm_ovf_cnt), 64'd0);
    model_reset();
    idle_in();
    @(negedge clk_sys);
    rst_n = 1'b1;
    cyc();

`ifdef FX_BM_TS_EN
    // Two writes three cycles apart.
    begin
      logic [TS_W-1:0] t0, t1;
      clr();
      wr(16'h0001, 8'h01);
      idle_in();
      cyc();
      cyc();
      wr(16'h0002, 8'h02);
      idle_in();
      cyc();
      t0 = bm_data[RW-1 -: TS_W];
      bm_rdy = 1'b1;
      cyc();
      bm_rdy = 1'b0;
      t1 = bm_data[RW-1 -: TS_W];
      chk("ts_delta", 64'(t1 - t0), 64'd3);
      bm_rdy = 1'b1;
      cyc();
      bm_rdy = 1'b0;
    end
`endif

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      fx_wr    = ($urandom_range(0, 1) == 0);
      fx_rd    = ($urandom_range(0, 2) == 0);
      fx_waddr = 16'($urandom_range(0, 1023));
      fx_raddr = 16'($urandom_range(0, 1023));
      fx_data  = 8'($urandom);
      fx_q     = 8'($urandom);
      bm_rdy   = ($urandom_range(0, 2) != 0);
      bm_clr   = ($urandom_range(0, 63) == 0);
      if ((i % 200) == 0) begin
        cfg_win_en = ($urandom_range(0, 1) == 0);
        cfg_lo     = 16'($urandom_range(0, 1023));
        cfg_hi     = 16'($urandom_range(0, 1023));
      end
      cyc();
    end
    idle_in();
    bm_clr = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
